// File: rtl/ifu_predecode_queue.sv
// Fetch-to-decode instruction queue with early b/bl redirect and wrong-path squash.
// Ports: clk, reset (async, active-high), flush; in_* fetch side (valid/ready);
//        out_* decode side (valid/ready, pred_taken, target); redirect_* to PC gen.
module ifu_predecode_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_pred_taken,
    output logic [31:0] out_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] target;
    } entry_t;

    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [31:0]   sq_target_q, sq_target_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;

    logic        is_br;
    logic [25:0] i26;
    logic [31:0] br_target;
    logic        full;
    logic        pc_match;
    logic        fire_in;
    logic        enq;
    logic        deq;

    assign i26       = {in_inst[9:0], in_inst[25:10]};
    assign br_target = in_pc + {{4{i26[25]}}, i26, 2'b00};
    assign is_br     = (in_inst[31:26] == 6'b010100) ||
                       (in_inst[31:26] == 6'b010101);
    assign full      = (count_q == FULL_CNT);
    assign pc_match  = (in_pc == sq_target_q);

    assign out_valid      = (count_q != '0);
    assign out_pc         = mem_q[rd_ptr_q].pc;
    assign out_inst       = mem_q[rd_ptr_q].inst;
    assign out_pred_taken = mem_q[rd_ptr_q].pred_taken;
    assign out_target     = mem_q[rd_ptr_q].target;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    // While squashing, wrong-path words are swallowed regardless of fullness;
    // only the awaited target must wait for a free slot.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            if (state_q == ST_SQUASH && !pc_match)
                in_ready = 1'b1;
            else
                in_ready = !full;
        end
    end

    assign fire_in = in_valid & in_ready;
    assign enq     = fire_in & ((state_q == ST_NORMAL) | pc_match);
    assign deq     = out_valid & out_ready & !flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = mem_q[i];
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        state_d          = state_q;
        sq_target_d      = sq_target_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (enq) begin
            mem_d[wr_ptr_q].pc         = in_pc;
            mem_d[wr_ptr_q].inst       = in_inst;
            mem_d[wr_ptr_q].pred_taken = is_br;
            mem_d[wr_ptr_q].target     = is_br ? br_target : 32'h0;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (is_br) begin
                sq_target_d      = br_target;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = br_target;
                state_d          = ST_SQUASH;
            end else begin
                state_d = ST_NORMAL;
            end
        end

        if (deq)
            rd_ptr_d = rd_ptr_q + 1'b1;

        if (enq && !deq)
            count_d = count_q + 1'b1;
        else if (!enq && deq)
            count_d = count_q - 1'b1;

        if (flush) begin
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
            state_d          = ST_NORMAL;
            redirect_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            state_q          <= ST_NORMAL;
            sq_target_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= mem_d[i];
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            state_q          <= state_d;
            sq_target_q      <= sq_target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

endmodule
